// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, byte/column types, the
// serializer FSM encoding and the ShiftRows source-byte lookup.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_COL_W   = 32;

   typedef logic [7:0] aes_byte_t;
   typedef logic [1:0] col_idx_t;

   typedef enum logic {
      SER_IDLE,
      SER_SEND
   } ser_state_e;

   // Source byte for (row, col) after ShiftRows: row r of output column c
   // comes from column (c + r) mod 4. Byte index is row + 4*column, which
   // the 2-bit wrap of col_idx_t turns into a simple concatenation.
   function automatic logic [3:0] shift_rows_byte_idx(input col_idx_t row,
                                                      input col_idx_t col);
      col_idx_t src_col;
      src_col = col + row;
      return {src_col, row};
   endfunction

endpackage

// File: rtl/shift_rows_col_sel.sv
// Combinational column picker: selects one ShiftRows output column
// from a full 128-bit state, row 0 in the most significant byte.
module shift_rows_col_sel
   import aes_pkg::*;
(
   input  logic [AES_STATE_W-1:0] state,
   input  col_idx_t               col_idx,
   output logic [AES_COL_W-1:0]   col_out
);

   aes_byte_t state_bytes [16];

   // Unpack the state into bytes, byte 0 in the most significant position.
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         state_bytes[k] = state[AES_STATE_W-1-8*k -: 8];
      end
   end

   // Gather the four row bytes of the requested column after ShiftRows.
   always_comb begin
      col_out = '0;
      for (int r = 0; r < 4; r++) begin
         col_out[AES_COL_W-1-8*r -: 8] =
            state_bytes[shift_rows_byte_idx(col_idx_t'(r), col_idx)];
      end
   end

endmodule

// File: rtl/shift_rows_col_serializer.sv
// ShiftRows plus state-to-column serializer feeding MixColumns. A state
// is held in st_q and emitted as four columns, one per handshake, with
// the final-round tag travelling alongside.
module shift_rows_col_serializer
   import aes_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int COL_WIDTH  = DATA_WIDTH / 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] state_in,
   input  logic                  state_valid,
   input  logic                  final_round_in,
   output logic                  state_ready,
   output logic [COL_WIDTH-1:0]  col_out,
   output logic                  col_valid,
   input  logic                  col_ready,
   output logic [1:0]            col_idx,
   output logic                  col_last,
   output logic                  final_round_out
);

   ser_state_e            fsm_q, fsm_d;
   logic [DATA_WIDTH-1:0] st_q;
   logic                  fr_q;
   col_idx_t              cnt_q;
   logic                  state_accept;
   logic                  col_accept;

   assign col_valid    = (fsm_q == SER_SEND);
   assign col_accept   = col_valid && col_ready;
   // Ready is combinational from col_ready so a new state can be taken on
   // the same edge the last column leaves, giving back-to-back streaming.
   assign state_ready  = (fsm_q == SER_IDLE) || ((cnt_q == 2'd3) && col_ready);
   assign state_accept = state_valid && state_ready;

   assign col_idx         = cnt_q;
   assign col_last        = (cnt_q == 2'd3);
   assign final_round_out = fr_q;

   // Column bytes are decoded purely from registered state and count.
   shift_rows_col_sel u_col_sel (
      .state   (st_q),
      .col_idx (cnt_q),
      .col_out (col_out)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= SER_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // Next state: leave IDLE on a new state, leave SEND after the last
   // column unless another state is accepted on that same handshake.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         SER_IDLE: if (state_accept) fsm_d = SER_SEND;
         SER_SEND: if (col_accept && (cnt_q == 2'd3) && !state_valid) fsm_d = SER_IDLE;
         default:  fsm_d = SER_IDLE;
      endcase
   end

   // Holding registers and column counter; the counter wraps 3 -> 0 so it
   // is already at zero for the next state, back-to-back or after IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= '0;
         fr_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (state_accept) begin
            st_q  <= state_in;
            fr_q  <= final_round_in;
            cnt_q <= '0;
         end else if (col_accept) begin
            cnt_q <= cnt_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_shift_rows_col_serializer.sv
// Self-checking bench: directed AES vectors plus randomized traffic,
// expected columns queued on each state handshake and popped by a monitor.
module tb_shift_rows_col_serializer;

   typedef struct packed {
      logic [31:0] col;
      logic [1:0]  idx;
      logic        last;
      logic        fr;
   } exp_col_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] state_in;
   logic         state_valid;
   logic         final_round_in;
   logic         state_ready;
   logic [31:0]  col_out;
   logic         col_valid;
   logic         col_ready;
   logic [1:0]   col_idx;
   logic         col_last;
   logic         final_round_out;

   exp_col_t     exp_q [$];
   int           assert_count = 0;
   int           fail_count   = 0;
   logic [31:0]  last_col0;

   shift_rows_col_serializer #(.DATA_WIDTH(128), .COL_WIDTH(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .state_in        (state_in),
      .state_valid     (state_valid),
      .final_round_in  (final_round_in),
      .state_ready     (state_ready),
      .col_out         (col_out),
      .col_valid       (col_valid),
      .col_ready       (col_ready),
      .col_idx         (col_idx),
      .col_last        (col_last),
      .final_round_out (final_round_out)
   );

   always #5 clk = ~clk;

   // Reference ShiftRows: output row r of column c is state byte
   // r + 4*((c + r) mod 4), byte k being the k-th byte from the top.
   function automatic logic [31:0] model_col(input logic [127:0] s, input int c);
      logic [31:0] res;
      logic [7:0]  bytes [16];
      for (int k = 0; k < 16; k++) bytes[k] = s[127-8*k -: 8];
      res = 0;
      for (int r = 0; r < 4; r++) res[31-8*r -: 8] = bytes[r + 4*((c + r) % 4)];
      return res;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m [4];
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      for (int i = 0; i < 4; i++)
         m[i] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      return {m[0], m[1], m[2], m[3]};
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic push_model(input logic [127:0] s, input logic fr);
      for (int c = 0; c < 4; c++)
         exp_q.push_back('{col: model_col(s, c), idx: 2'(c), last: (c == 3), fr: fr});
   endtask

   task automatic push_const(input logic [31:0] c0, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3,
                             input logic fr);
      exp_q.push_back('{col: c0, idx: 2'd0, last: 1'b0, fr: fr});
      exp_q.push_back('{col: c1, idx: 2'd1, last: 1'b0, fr: fr});
      exp_q.push_back('{col: c2, idx: 2'd2, last: 1'b0, fr: fr});
      exp_q.push_back('{col: c3, idx: 2'd3, last: 1'b1, fr: fr});
   endtask

   // One cycle of stimulus; acc reports whether the state handshake
   // happens at the coming rising edge.
   task automatic apply_stimulus(input logic sv, input logic [127:0] d,
                                 input logic fr, input logic cr, output bit acc);
      @(negedge clk);
      state_valid    = sv;
      state_in       = d;
      final_round_in = fr;
      col_ready      = cr;
      #1;
      acc = sv && state_ready;
   endtask

   task automatic offer_state(input logic [127:0] d, input logic fr, output bit ok);
      bit acc;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         apply_stimulus(1'b1, d, fr, 1'b1, acc);
         ok = acc;
      end
      if (!ok) check_output("offer_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_cycles(input int n, input logic cr);
      bit acc;
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, cr, acc);
   endtask

   // Monitor: samples just after inputs settle; a column with valid and
   // ready high is taken at the next edge and is checked against the queue.
   initial begin : monitor
      bit       prev_stall;
      exp_col_t held;
      exp_col_t e;
      prev_stall = 0;
      held = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n || !col_valid) begin
            prev_stall = 0;
         end else begin
            if (prev_stall)
               check_output("stall_hold", {col_out[31:0]} ^ {28'd0, col_idx, col_last, final_round_out},
                            held.col ^ {28'd0, held.idx, held.last, held.fr});
            if (col_ready) begin
               prev_stall = 0;
               if (exp_q.size() == 0) begin
                  check_output("unexpected_col", col_out, 32'hxxxxxxxx);
               end else begin
                  e = exp_q.pop_front();
                  check_output("col_out", col_out, e.col);
                  check_output("col_idx", {30'd0, col_idx}, {30'd0, e.idx});
                  check_output("col_last", {31'd0, col_last}, {31'd0, e.last});
                  check_output("final_round_out", {31'd0, final_round_out}, {31'd0, e.fr});
               end
               if (col_idx == 2'd0) last_col0 = col_out;
            end else begin
               prev_stall = 1;
               held = '{col: col_out, idx: col_idx, last: col_last, fr: final_round_out};
            end
         end
      end
   end

   // Main stimulus sequence.
   initial begin : stim
      bit          ok;
      bit          acc;
      bit          have;
      int          accepted;
      int          budget;
      logic [127:0] d;
      logic         fr;
      logic [127:0] st_a;
      logic [127:0] st_b;

      st_a = 128'hd42711aee0bf98f1b8b45de51e415230;
      st_b = 128'h000102030405060708090a0b0c0d0e0f;
      rst_n = 1'b0;
      state_valid = 1'b0;
      state_in = '0;
      final_round_in = 1'b0;
      col_ready = 1'b0;
      last_col0 = '0;

      // Reset values.
      #12;
      check_output("rst_col_valid", {31'd0, col_valid}, 32'd0);
      check_output("rst_col_out", col_out, 32'd0);
      check_output("rst_col_idx", {30'd0, col_idx}, 32'd0);
      check_output("rst_col_last", {31'd0, col_last}, 32'd0);
      check_output("rst_final_round", {31'd0, final_round_out}, 32'd0);
      check_output("rst_state_ready", {31'd0, state_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Known AES vector, plus MixColumns on the first emitted column.
      offer_state(st_a, 1'b0, ok);
      if (ok) push_const(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 1'b0);
      idle_cycles(6, 1'b1);
      check_output("mixcol_col0", mix_column(last_col0), 32'h046681e5);

      // Back-to-back: A then identity vector tagged final round.
      offer_state(st_a, 1'b0, ok);
      if (ok) push_const(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 1'b0);
      for (int w = 1; w <= 8; w++) begin
         apply_stimulus(w <= 4, st_b, 1'b1, 1'b1, acc);
         check_output("b2b_col_valid", {31'd0, col_valid}, 32'd1);
         check_output("b2b_state_ready", {31'd0, state_ready}, {31'd0, (w == 4 || w == 8)});
         if (acc && w <= 4)
            push_const(32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b, 1'b1);
      end
      idle_cycles(1, 1'b1);
      check_output("b2b_end_idle", {31'd0, col_valid}, 32'd0);
      idle_cycles(2, 1'b1);

      // Backpressure for three cycles at column 1.
      d = {$urandom, $urandom, $urandom, $urandom};
      offer_state(d, 1'b0, ok);
      if (ok) push_model(d, 1'b0);
      idle_cycles(1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, ~d, 1'b1, 1'b0, acc);
         check_output("bp_col_idx", {30'd0, col_idx}, 32'd1);
         check_output("bp_col_out", col_out, model_col(d, 1));
         check_output("bp_state_ready", {31'd0, state_ready}, 32'd0);
      end
      idle_cycles(5, 1'b1);

      // Asynchronous reset after column 1 has been taken.
      d = {$urandom, $urandom, $urandom, $urandom};
      offer_state(d, 1'b1, ok);
      if (ok) push_model(d, 1'b1);
      idle_cycles(2, 1'b1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, acc);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_col_valid", {31'd0, col_valid}, 32'd0);
      check_output("mid_rst_col_out", col_out, 32'd0);
      check_output("mid_rst_col_idx", {30'd0, col_idx}, 32'd0);
      check_output("mid_rst_final_round", {31'd0, final_round_out}, 32'd0);
      check_output("mid_rst_state_ready", {31'd0, state_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      offer_state(d, 1'b0, ok);
      if (ok) push_model(d, 1'b0);
      idle_cycles(6, 1'b1);

      // Randomized traffic with random valid and ready.
      have = 0;
      accepted = 0;
      budget = 0;
      while (accepted < 40 && budget < 3000) begin
         if (!have) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            fr = 1'($urandom_range(0, 1));
            have = 1;
         end
         apply_stimulus(($urandom_range(0, 3) != 0), d, fr, ($urandom_range(0, 3) != 0), acc);
         if (acc) begin
            push_model(d, fr);
            have = 0;
            accepted++;
         end
         budget++;
      end
      if (accepted < 40) check_output("random_budget", 32'(accepted), 32'd40);

      // Drain the scoreboard.
      budget = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         idle_cycles(1, 1'b1);
         budget++;
      end
      idle_cycles(2, 1'b1);
      check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
